count_sampler: RTL and testbench

- Synchronous consumer for the 4-bit ripple counter output. Takes the raw, rippling count bus into the `clk` domain and filters out transient intermediate codes.
- Publishes a clean count value and one-cycle event pulses (step, wrap, match), a saturating wrap counter and a sticky sequence-error flag.
- Sits directly downstream of the ripple counter and feeds control/readout logic.

---
 rtl/count_sampler_if.sv | 32 +++
 rtl/count_sampler.sv | 183 ++++++++++++++++++
 tb/tb_count_sampler.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_sampler_if.sv
// Bus bundle between the count sampler and its consumer: raw count and
// control inputs in, filtered count, event pulses and status out.
interface count_sampler_if #(
    parameter int W      = 4,
    parameter int WRAP_W = 8
);
    logic [W-1:0]      cnt_in;
    logic              en;
    logic [W-1:0]      match_val;
    logic              err_clr;
    logic [W-1:0]      cnt_out;
    logic              cnt_valid;
    logic              step_pulse;
    logic              wrap_pulse;
    logic              match_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic              err;

    // Side that drives the raw count and controls, and reads the results.
    modport master (
        output cnt_in, en, match_val, err_clr,
        input  cnt_out, cnt_valid, step_pulse, wrap_pulse, match_pulse,
               wrap_count, err
    );

    // The sampler itself.
    modport slave (
        input  cnt_in, en, match_val, err_clr,
        output cnt_out, cnt_valid, step_pulse, wrap_pulse, match_pulse,
               wrap_count, err
    );
endinterface

// File: rtl/count_sampler.sv
// Count sampler: brings a rippling counter bus into the clk domain, accepts a
// code only once it has been seen on STABLE_N consecutive samples, and tracks
// the accepted sequence (step / wrap / match events, wrap count, sticky error).
module count_sampler #(
    parameter int W        = 4,
    parameter int WRAP_W   = 8,
    parameter int STABLE_N = 2
) (
    input  logic              clk,
    input  logic              clr,
    count_sampler_if.slave    bus
);
    localparam int                HOLD_W   = $clog2(STABLE_N + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STABLE_N);
    localparam logic [W-1:0]      CNT_MAX  = {W{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    // Sampling pipeline
    logic [W-1:0]      r_s1;
    logic [W-1:0]      r_s2;
    logic              r_s1_vld;
    logic              r_s2_vld;
    logic [HOLD_W-1:0] r_hold;

    // Tracking state and registered outputs
    state_t            r_state;
    logic [W-1:0]      r_cnt;
    logic              r_valid;
    logic              r_step;
    logic              r_wrap;
    logic              r_match;
    logic [WRAP_W-1:0] r_wraps;
    logic              r_err;

    // Combinational helpers and next-state values
    logic              w_eq;
    logic              w_stable;
    logic [HOLD_W-1:0] w_hold_next;
    logic [W-1:0]      w_inc;
    state_t            w_state_next;
    logic [W-1:0]      w_cnt_next;
    logic              w_valid_next;
    logic              w_step_next;
    logic              w_wrap_next;
    logic              w_match_next;
    logic [WRAP_W-1:0] w_wraps_next;
    logic              w_err_next;

    // The zeros left in s1/s2 by reset are not real samples of the bus, so a
    // comparison only counts once s2 holds something sampled after reset.
    // Without this, the reset value 0 would be accepted right after release.
    assign w_eq     = r_s2_vld && (r_s1 == r_s2);
    assign w_stable = w_eq && ((int'(r_hold) + 2) >= STABLE_N);
    assign w_inc    = r_cnt + W'(1);

    always_comb begin
        w_hold_next = '0;
        if (w_eq) begin
            w_hold_next = (r_hold == HOLD_MAX) ? r_hold : r_hold + HOLD_W'(1);
        end
    end

    // Two-stage sampler of the asynchronous count bus plus stability run length.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_s1     <= bus.cnt_in;
            r_s2     <= r_s1;
            r_s1_vld <= 1'b1;
            r_s2_vld <= r_s1_vld;
            r_hold   <= w_hold_next;
        end
    end

    // Next-state and output decode for the INIT / TRACK / ERR tracker.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_valid_next = r_valid;
        w_step_next  = 1'b0;
        w_wrap_next  = 1'b0;
        w_match_next = 1'b0;
        w_wraps_next = r_wraps;
        w_err_next   = r_err;

        case (r_state)
            ST_INIT: begin
                // First stable value after enable is taken even if it equals
                // the held cnt_out, so tracking restarts from a known value.
                if (bus.en && w_stable) begin
                    w_cnt_next   = r_s2;
                    w_valid_next = 1'b1;
                    w_state_next = ST_TRACK;
                    w_match_next = (r_s2 == bus.match_val);
                end
            end

            ST_TRACK: begin
                if (!bus.en) begin
                    w_state_next = ST_INIT;
                    w_valid_next = 1'b0;
                end else if (w_stable && (r_s2 != r_cnt)) begin
                    w_cnt_next = r_s2;
                    if (r_s2 == w_inc) begin
                        w_step_next  = 1'b1;
                        w_match_next = (r_s2 == bus.match_val);
                        if (r_cnt == CNT_MAX) begin
                            w_wrap_next = 1'b1;
                            if (r_wraps != WRAP_MAX) begin
                                w_wraps_next = r_wraps + WRAP_W'(1);
                            end
                        end
                    end else if (r_s2 == '0) begin
                        // Upstream counter was cleared: plain reload.
                        w_match_next = (r_s2 == bus.match_val);
                    end else begin
                        w_err_next   = 1'b1;
                        w_valid_next = 1'b0;
                        w_state_next = ST_ERR;
                    end
                end
            end

            ST_ERR: begin
                // Keep following the bus silently until software clears.
                if (w_stable && (r_s2 != r_cnt)) begin
                    w_cnt_next = r_s2;
                end
                if (bus.err_clr) begin
                    w_err_next   = 1'b0;
                    w_state_next = ST_INIT;
                end
            end

            default: begin
                w_state_next = ST_INIT;
                w_valid_next = 1'b0;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
            r_match <= 1'b0;
            r_wraps <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_valid <= w_valid_next;
            r_step  <= w_step_next;
            r_wrap  <= w_wrap_next;
            r_match <= w_match_next;
            r_wraps <= w_wraps_next;
            r_err   <= w_err_next;
        end
    end

    assign bus.cnt_out     = r_cnt;
    assign bus.cnt_valid   = r_valid;
    assign bus.step_pulse  = r_step;
    assign bus.wrap_pulse  = r_wrap;
    assign bus.match_pulse = r_match;
    assign bus.wrap_count  = r_wraps;
    assign bus.err         = r_err;
endmodule

// File: tb/tb_count_sampler.sv
// Bench for count_sampler: two instances (STABLE_N=2/WRAP_W=8 and
// STABLE_N=3/WRAP_W=2) share one stimulus stream; every cycle both are
// compared with a sample-history reference model, plus directed checks.
module tb_count_sampler;
    localparam int S_INIT  = 0;
    localparam int S_TRACK = 1;
    localparam int S_ERR   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    logic [3:0] t_cnt;
    logic [3:0] t_mv;
    logic       t_en;
    logic       t_eclr;

    count_sampler_if #(.W(4), .WRAP_W(8)) bus0 ();
    count_sampler_if #(.W(4), .WRAP_W(2)) bus1 ();

    assign bus0.cnt_in    = t_cnt;
    assign bus0.en        = t_en;
    assign bus0.match_val = t_mv;
    assign bus0.err_clr   = t_eclr;
    assign bus1.cnt_in    = t_cnt;
    assign bus1.en        = t_en;
    assign bus1.match_val = t_mv;
    assign bus1.err_clr   = t_eclr;

    count_sampler #(.W(4), .WRAP_W(8), .STABLE_N(2)) dut0 (
        .clk (clk),
        .clr (clr),
        .bus (bus0)
    );

    count_sampler #(.W(4), .WRAP_W(2), .STABLE_N(3)) dut1 (
        .clk (clk),
        .clr (clr),
        .bus (bus1)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Reference model: bus samples taken since reset, newest at the back.
    int hist[$];
    int m_n[2]    = '{2, 3};
    int m_wmax[2] = '{255, 3};
    int m_state[2], m_cnt[2], m_valid[2], m_wraps[2], m_err[2];
    int m_step[2], m_wrap[2], m_match[2];
    int n_step[2], n_wrap[2], n_match[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // Value seen on the last n samples, or -1 if they were not all equal.
    function automatic int settled(input int n);
        int last;
        if (hist.size() < n) return -1;
        last = hist[hist.size()-1];
        for (int i = 1; i <= n; i++) begin
            if (hist[hist.size()-i] != last) return -1;
        end
        return last;
    endfunction

    task automatic model_edge(input int k);
        int v;
        int old;
        v = settled(m_n[k]);
        m_step[k]  = 0;
        m_wrap[k]  = 0;
        m_match[k] = 0;
        if (!clr) begin
            m_state[k] = S_INIT;
            m_cnt[k]   = 0;
            m_valid[k] = 0;
            m_wraps[k] = 0;
            m_err[k]   = 0;
            return;
        end
        case (m_state[k])
            S_INIT: begin
                if (t_en && v >= 0) begin
                    m_cnt[k]   = v;
                    m_valid[k] = 1;
                    m_state[k] = S_TRACK;
                    m_match[k] = (v == int'(t_mv)) ? 1 : 0;
                end
            end
            S_TRACK: begin
                if (!t_en) begin
                    m_state[k] = S_INIT;
                    m_valid[k] = 0;
                end else if (v >= 0 && v != m_cnt[k]) begin
                    old      = m_cnt[k];
                    m_cnt[k] = v;
                    if (v == (old + 1) % 16) begin
                        m_step[k]  = 1;
                        m_match[k] = (v == int'(t_mv)) ? 1 : 0;
                        if (old == 15) begin
                            m_wrap[k] = 1;
                            if (m_wraps[k] < m_wmax[k]) m_wraps[k]++;
                        end
                    end else if (v == 0) begin
                        m_match[k] = (v == int'(t_mv)) ? 1 : 0;
                    end else begin
                        m_err[k]   = 1;
                        m_valid[k] = 0;
                        m_state[k] = S_ERR;
                    end
                end
            end
            S_ERR: begin
                if (v >= 0 && v != m_cnt[k]) m_cnt[k] = v;
                if (t_eclr) begin
                    m_err[k]   = 0;
                    m_state[k] = S_INIT;
                end
            end
            default: ;
        endcase
    endtask

    task automatic clr_counts();
        for (int k = 0; k < 2; k++) begin
            n_step[k]  = 0;
            n_wrap[k]  = 0;
            n_match[k] = 0;
        end
    endtask

    // One clock: advance the model on the current inputs, clock the DUTs,
    // then compare every output of both instances.
    task automatic tick();
        model_edge(0);
        model_edge(1);
        if (!clr) hist.delete();
        else begin
            hist.push_back(int'(t_cnt));
            if (hist.size() > 8) void'(hist.pop_front());
        end
        @(posedge clk);
        #1;
        cycle++;
        chk("d0.cnt_out",     32'(bus0.cnt_out),     32'(m_cnt[0]));
        chk("d0.cnt_valid",   32'(bus0.cnt_valid),   32'(m_valid[0]));
        chk("d0.step_pulse",  32'(bus0.step_pulse),  32'(m_step[0]));
        chk("d0.wrap_pulse",  32'(bus0.wrap_pulse),  32'(m_wrap[0]));
        chk("d0.match_pulse", 32'(bus0.match_pulse), 32'(m_match[0]));
        chk("d0.wrap_count",  32'(bus0.wrap_count),  32'(m_wraps[0]));
        chk("d0.err",         32'(bus0.err),         32'(m_err[0]));
        chk("d1.cnt_out",     32'(bus1.cnt_out),     32'(m_cnt[1]));
        chk("d1.cnt_valid",   32'(bus1.cnt_valid),   32'(m_valid[1]));
        chk("d1.step_pulse",  32'(bus1.step_pulse),  32'(m_step[1]));
        chk("d1.wrap_pulse",  32'(bus1.wrap_pulse),  32'(m_wrap[1]));
        chk("d1.match_pulse", 32'(bus1.match_pulse), 32'(m_match[1]));
        chk("d1.wrap_count",  32'(bus1.wrap_count),  32'(m_wraps[1]));
        chk("d1.err",         32'(bus1.err),         32'(m_err[1]));
        n_step[0]  += int'(bus0.step_pulse);
        n_wrap[0]  += int'(bus0.wrap_pulse);
        n_match[0] += int'(bus0.match_pulse);
        n_step[1]  += int'(bus1.step_pulse);
        n_wrap[1]  += int'(bus1.wrap_pulse);
        n_match[1] += int'(bus1.match_pulse);
    endtask

    task automatic hold(input int v, input int n);
        t_cnt = 4'(v);
        repeat (n) tick();
    endtask

    initial begin
        int cur;
        clr    = 1'b0;
        t_cnt  = 4'hA;
        t_en   = 1'b1;
        t_mv   = 4'hF;
        t_eclr = 1'b0;
        clr_counts();

        // Reset held for two edges with a live bus value.
        tick();
        tick();
        $display("reset: cycle %0d cnt_out=%0d valid=%0d", cycle, bus0.cnt_out, bus0.cnt_valid);
        chk("rst.cnt_out",    32'(bus0.cnt_out),    32'd0);
        chk("rst.valid",      32'(bus0.cnt_valid),  32'd0);
        chk("rst.err",        32'(bus0.err),        32'd0);
        chk("rst.wrap_count", 32'(bus0.wrap_count), 32'd0);
        chk("rst.d1_valid",   32'(bus1.cnt_valid),  32'd0);

        // Release: first acceptance three edges later (one more for STABLE_N=3).
        clr = 1'b1;
        tick();
        chk("rel1.valid", 32'(bus0.cnt_valid), 32'd0);
        tick();
        chk("rel2.valid", 32'(bus0.cnt_valid), 32'd0);
        tick();
        chk("rel3.valid",   32'(bus0.cnt_valid),  32'd1);
        chk("rel3.cnt_out", 32'(bus0.cnt_out),    32'hA);
        chk("rel3.step",    32'(bus0.step_pulse), 32'd0);
        chk("rel3.d1_valid", 32'(bus1.cnt_valid), 32'd0);
        tick();
        chk("rel4.d1_valid", 32'(bus1.cnt_valid), 32'd1);
        repeat (6) tick();
        $display("release: cycle %0d cnt_out=%0d", cycle, bus0.cnt_out);

        // Full count 0..15..0, ten cycles per value.
        clr_counts();
        for (int v = 0; v <= 16; v++) hold(v % 16, 10);
        $display("count: cycle %0d steps=%0d wraps=%0d", cycle, n_step[0], n_wrap[0]);
        chk("count.steps0", 32'(n_step[0]), 32'd16);
        chk("count.steps1", 32'(n_step[1]), 32'd16);
        chk("count.wraps0", 32'(n_wrap[0]), 32'd1);
        chk("count.wcnt0",  32'(bus0.wrap_count), 32'd1);
        chk("count.err0",   32'(bus0.err), 32'd0);

        // One-sample glitch 3 -> 0 -> 4 is rejected by both.
        hold(1, 6);
        hold(2, 6);
        hold(3, 6);
        clr_counts();
        hold(0, 1);
        hold(4, 10);
        $display("glitch1: cycle %0d cnt_out=%0d/%0d", cycle, bus0.cnt_out, bus1.cnt_out);
        chk("g1.cnt0",   32'(bus0.cnt_out), 32'd4);
        chk("g1.steps0", 32'(n_step[0]),    32'd1);
        chk("g1.err0",   32'(bus0.err),     32'd0);
        chk("g1.steps1", 32'(n_step[1]),    32'd1);

        // Two-sample glitch: rejected with STABLE_N=3, accepted as a reload
        // (then an error on 5) with STABLE_N=2.
        clr_counts();
        hold(0, 2);
        hold(5, 10);
        $display("glitch2: cycle %0d err=%0d/%0d", cycle, bus0.err, bus1.err);
        chk("g2.cnt1",   32'(bus1.cnt_out), 32'd5);
        chk("g2.steps1", 32'(n_step[1]),    32'd1);
        chk("g2.err1",   32'(bus1.err),     32'd0);
        chk("g2.err0",   32'(bus0.err),     32'd1);
        t_eclr = 1'b1;
        tick();
        t_eclr = 1'b0;
        repeat (6) tick();

        // Sequence error 5 -> 9, then clear.
        clr_counts();
        hold(9, 10);
        $display("error: cycle %0d err=%0d cnt_out=%0d", cycle, bus0.err, bus0.cnt_out);
        chk("e.err0",    32'(bus0.err),       32'd1);
        chk("e.valid0",  32'(bus0.cnt_valid), 32'd0);
        chk("e.cnt0",    32'(bus0.cnt_out),   32'd9);
        chk("e.pulses0", 32'(n_step[0] + n_wrap[0] + n_match[0]), 32'd0);
        chk("e.err1",    32'(bus1.err),       32'd1);
        t_eclr = 1'b1;
        tick();
        t_eclr = 1'b0;
        chk("eclr.err0",   32'(bus0.err),       32'd0);
        chk("eclr.valid0", 32'(bus0.cnt_valid), 32'd0);
        tick();
        chk("eclr.revalid0", 32'(bus0.cnt_valid), 32'd1);
        chk("eclr.revalid1", 32'(bus1.cnt_valid), 32'd1);

        // Upstream clear from 7 with match_val = 0.
        hold(0, 6);
        for (int v = 1; v <= 7; v++) hold(v, 6);
        t_mv = 4'h0;
        clr_counts();
        hold(0, 10);
        $display("reload: cycle %0d matches=%0d steps=%0d", cycle, n_match[0], n_step[0]);
        chk("rl.cnt0",    32'(bus0.cnt_out), 32'd0);
        chk("rl.match0",  32'(n_match[0]),   32'd1);
        chk("rl.steps0",  32'(n_step[0]),    32'd0);
        chk("rl.wraps0",  32'(n_wrap[0]),    32'd0);
        chk("rl.err0",    32'(bus0.err),     32'd0);
        chk("rl.match1",  32'(n_match[1]),   32'd1);

        // Five full cycles: WRAP_W=2 instance saturates at 3.
        t_mv = 4'hF;
        clr_counts();
        for (int r = 0; r < 5; r++) begin
            for (int v = 1; v <= 16; v++) hold(v % 16, 4);
        end
        $display("wraps: cycle %0d wrap_count=%0d/%0d", cycle, bus0.wrap_count, bus1.wrap_count);
        chk("w.pulses1", 32'(n_wrap[1]),        32'd5);
        chk("w.count1",  32'(bus1.wrap_count),  32'd3);
        chk("w.pulses0", 32'(n_wrap[0]),        32'd5);
        chk("w.count0",  32'(bus0.wrap_count),  32'd6);

        // Drop enable while tracking.
        t_en = 1'b0;
        tick();
        chk("en.valid0", 32'(bus0.cnt_valid), 32'd0);
        chk("en.cnt0",   32'(bus0.cnt_out),   32'd0);
        chk("en.valid1", 32'(bus1.cnt_valid), 32'd0);
        repeat (3) tick();
        t_en = 1'b1;
        repeat (6) tick();
        $display("enable: cycle %0d valid=%0d", cycle, bus0.cnt_valid);

        // Randomized traffic: mostly counting, with glitches, jumps,
        // error clears, short enable drops and occasional resets.
        cur = int'(bus0.cnt_out);
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 15)      cur = (cur + 1) % 16;
            else if (r < 17) cur = $urandom_range(0, 15);
            if (r >= 17 && r < 20) t_cnt = 4'($urandom_range(0, 15));
            else                   t_cnt = 4'(cur);
            t_eclr = ($urandom_range(0, 29) == 0);
            t_en   = !((m_state[0] == S_TRACK) && (m_state[1] == S_TRACK) &&
                       ($urandom_range(0, 49) == 0));
            clr    = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 59) == 0) t_mv = 4'($urandom_range(0, 15));
            tick();
        end
        t_eclr = 1'b0;
        t_en   = 1'b1;
        clr    = 1'b1;
        $display("random: cycle %0d errors so far %0d", cycle, errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
